// File: rtl/vx_barrier_table.sv
// vx_barrier_table
//   Table of NUM_BARRIERS concurrent warp barriers for the warp-control path.
//   Each slot counts arriving warps and holds their bits in an arrival mask.
//   The arrival that completes a barrier loads a one-deep release register,
//   which the scheduler drains with a valid/ready handshake.
//
// Optional feature macro: BAR_PERF_EN
//   defined   : perf_stall_cycles accumulates popcount(stalled_wmask) each cycle
//   undefined : perf_stall_cycles is tied to zero and the counter is not built
//
// Ports
//   clk                clock
//   reset              synchronous reset, active low, sampled at posedge clk
//   bar_valid/ready    arrival handshake (ready = release register can take one)
//   bar_wid            arriving warp id
//   bar_id             barrier slot
//   bar_size_m1        participating warps minus one (value of completing arrival wins)
//   bar_is_noop        accept and discard
//   release_valid/ready release handshake to the scheduler
//   release_id         completed barrier slot
//   release_wmask      warps to resume
//   stalled_wmask      registered OR of all slot arrival masks
//   busy               any slot has arrivals, or a release is pending
//   perf_stall_cycles  warp-cycles spent stalled

// Checker: a warp arriving twice at the same barrier is dropped by the table;
// this flags the event in simulation without stopping the run.
module vx_barrier_table_chk (
  input logic clk,
  input logic reset,
  input logic dup_arrival
);

  // Duplicate arrivals are a software/protocol bug upstream.
  dup_arrival_a: assert property (@(posedge clk) disable iff (!reset) !dup_arrival)
    else $warning("vx_barrier_table: duplicate barrier arrival ignored");

endmodule

module vx_barrier_table #(
  parameter int NUM_WARPS     = 4,
  parameter int NUM_BARRIERS  = 4,
  parameter int PERF_CTR_BITS = 44,
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bar_valid,
  output logic                     bar_ready,
  input  logic [NW_W-1:0]          bar_wid,
  input  logic [NB_W-1:0]          bar_id,
  input  logic [NW_W-1:0]          bar_size_m1,
  input  logic                     bar_is_noop,
  output logic                     release_valid,
  input  logic                     release_ready,
  output logic [NB_W-1:0]          release_id,
  output logic [NUM_WARPS-1:0]     release_wmask,
  output logic [NUM_WARPS-1:0]     stalled_wmask,
  output logic                     busy,
  output logic [PERF_CTR_BITS-1:0] perf_stall_cycles
);

  // One-hot decode of a warp id; ids beyond NUM_WARPS decode to zero.
  function automatic logic [NUM_WARPS-1:0] warp_onehot(input logic [NW_W-1:0] wid);
    logic [NUM_WARPS-1:0] oh;
    oh = {NUM_WARPS{1'b0}};
    for (int i = 0; i < NUM_WARPS; i++) begin
      oh[i] = (NW_W'(i) == wid);
    end
    return oh;
  endfunction

  // Per-slot state
  logic [NW_W-1:0]      count_r     [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_r     [NUM_BARRIERS];
  logic [NW_W-1:0]      count_n_s   [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_n_s   [NUM_BARRIERS];

  // Release register and registered status outputs
  logic                 rel_valid_r;
  logic                 rel_valid_n_s;
  logic [NB_W-1:0]      rel_id_r;
  logic [NB_W-1:0]      rel_id_n_s;
  logic [NUM_WARPS-1:0] rel_wmask_r;
  logic [NUM_WARPS-1:0] rel_wmask_n_s;
  logic [NUM_WARPS-1:0] stalled_r;
  logic [NUM_WARPS-1:0] stalled_n_s;
  logic                 busy_r;
  logic                 busy_n_s;

  // Request decode
  logic                 fire_s;
  logic                 hit_s;
  logic                 seen_s;
  logic                 dup_s;
  logic                 complete_s;
  logic                 arrive_s;
  logic [NUM_WARPS-1:0] wid_oh_s;
  logic [NW_W-1:0]      sel_count_s;
  logic [NUM_WARPS-1:0] sel_wmask_s;

  // Only combinational path: a release drained this cycle frees the register
  // for a completing arrival in the same cycle.
  assign bar_ready = !rel_valid_r || release_ready;
  assign fire_s    = bar_valid && bar_ready;
  assign wid_oh_s  = warp_onehot(bar_wid);

  // Read the addressed slot; out-of-range ids hit nothing and are discarded.
  always_comb begin
    hit_s       = 1'b0;
    sel_count_s = {NW_W{1'b0}};
    sel_wmask_s = {NUM_WARPS{1'b0}};
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      hit_s       = hit_s | (NB_W'(b) == bar_id);
      sel_count_s = sel_count_s | ({NW_W{NB_W'(b) == bar_id}} & count_r[b]);
      sel_wmask_s = sel_wmask_s | ({NUM_WARPS{NB_W'(b) == bar_id}} & wmask_r[b]);
    end
  end

  // Classify the accepted request; a duplicate wins over completion.
  assign seen_s     = |(sel_wmask_s & wid_oh_s);
  assign dup_s      = fire_s && hit_s && !bar_is_noop && seen_s;
  assign complete_s = fire_s && hit_s && !bar_is_noop && !seen_s && (sel_count_s == bar_size_m1);
  assign arrive_s   = fire_s && hit_s && !bar_is_noop && !seen_s && (sel_count_s != bar_size_m1);

  // Release register next state: drain on handshake, reload on completion.
  always_comb begin
    rel_valid_n_s = rel_valid_r;
    rel_id_n_s    = rel_id_r;
    rel_wmask_n_s = rel_wmask_r;
    if (rel_valid_r && release_ready) begin
      rel_valid_n_s = 1'b0;
      rel_id_n_s    = {NB_W{1'b0}};
      rel_wmask_n_s = {NUM_WARPS{1'b0}};
    end else begin
      rel_valid_n_s = rel_valid_r;
    end
    if (complete_s) begin
      rel_valid_n_s = 1'b1;
      rel_id_n_s    = bar_id;
      rel_wmask_n_s = sel_wmask_s | wid_oh_s;
    end else begin
      rel_id_n_s = rel_id_n_s;
    end
  end

  // Slot next state plus the derived stall mask and busy flag.
  always_comb begin
    stalled_n_s = {NUM_WARPS{1'b0}};
    busy_n_s    = rel_valid_n_s;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      count_n_s[b] = count_r[b];
      wmask_n_s[b] = wmask_r[b];
      if (complete_s && (NB_W'(b) == bar_id)) begin
        count_n_s[b] = {NW_W{1'b0}};
        wmask_n_s[b] = {NUM_WARPS{1'b0}};
      end else if (arrive_s && (NB_W'(b) == bar_id)) begin
        count_n_s[b] = count_r[b] + NW_W'(1);
        wmask_n_s[b] = wmask_r[b] | wid_oh_s;
      end else begin
        count_n_s[b] = count_r[b];
      end
      stalled_n_s = stalled_n_s | wmask_n_s[b];
      busy_n_s    = busy_n_s | (|count_n_s[b]);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        count_r[b] <= {NW_W{1'b0}};
        wmask_r[b] <= {NUM_WARPS{1'b0}};
      end
      rel_valid_r <= 1'b0;
      rel_id_r    <= {NB_W{1'b0}};
      rel_wmask_r <= {NUM_WARPS{1'b0}};
      stalled_r   <= {NUM_WARPS{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        count_r[b] <= count_n_s[b];
        wmask_r[b] <= wmask_n_s[b];
      end
      rel_valid_r <= rel_valid_n_s;
      rel_id_r    <= rel_id_n_s;
      rel_wmask_r <= rel_wmask_n_s;
      stalled_r   <= stalled_n_s;
      busy_r      <= busy_n_s;
    end
  end

  assign release_valid = rel_valid_r;
  assign release_id    = rel_id_r;
  assign release_wmask = rel_wmask_r;
  assign stalled_wmask = stalled_r;
  assign busy          = busy_r;

`ifdef BAR_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_r;

  // Number of set bits in a warp mask, widened to the counter width.
  function automatic logic [PERF_CTR_BITS-1:0] popcount(input logic [NUM_WARPS-1:0] m);
    logic [PERF_CTR_BITS-1:0] sum;
    sum = {PERF_CTR_BITS{1'b0}};
    for (int i = 0; i < NUM_WARPS; i++) begin
      sum = sum + {{(PERF_CTR_BITS-1){1'b0}}, m[i]};
    end
    return sum;
  endfunction

  // Stall counter: accumulates stalled warps every cycle, wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_r <= {PERF_CTR_BITS{1'b0}};
    end else begin
      perf_r <= perf_r + popcount(stalled_r);
    end
  end

  assign perf_stall_cycles = perf_r;
`else
  assign perf_stall_cycles = {PERF_CTR_BITS{1'b0}};
`endif

  vx_barrier_table_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .dup_arrival (dup_s)
  );

endmodule

// File: tb/tb_vx_barrier_table.sv
module tb_vx_barrier_table;

`ifdef BAR_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        bar_valid;
  logic        bar_ready;
  logic [1:0]  bar_wid;
  logic [1:0]  bar_id;
  logic [1:0]  bar_size_m1;
  logic        bar_is_noop;
  logic        release_valid;
  logic        release_ready;
  logic [1:0]  release_id;
  logic [3:0]  release_wmask;
  logic [3:0]  stalled_wmask;
  logic        busy;
  logic [43:0] perf_stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_barrier_table #(.NUM_WARPS(4), .NUM_BARRIERS(4), .PERF_CTR_BITS(44)) dut (
    .clk               (clk),
    .reset             (reset),
    .bar_valid         (bar_valid),
    .bar_ready         (bar_ready),
    .bar_wid           (bar_wid),
    .bar_id            (bar_id),
    .bar_size_m1       (bar_size_m1),
    .bar_is_noop       (bar_is_noop),
    .release_valid     (release_valid),
    .release_ready     (release_ready),
    .release_id        (release_id),
    .release_wmask     (release_wmask),
    .stalled_wmask     (stalled_wmask),
    .busy              (busy),
    .perf_stall_cycles (perf_stall_cycles)
  );

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [1:0] wid;
    logic [1:0] id;
    logic [1:0] sz;
    logic       noop;
    logic       rr;
    logic       br;
    logic       rv;
    logic [1:0] rid;
    logic [3:0] rmask;
    logic [3:0] st;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic valid, logic [1:0] wid, logic [1:0] id,
                              logic [1:0] sz, logic noop, logic rr, logic br, logic rv,
                              logic [1:0] rid, logic [3:0] rmask, logic [3:0] st, logic bsy);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.wid = wid; v.id = id; v.sz = sz; v.noop = noop;
    v.rr = rr; v.br = br; v.rv = rv; v.rid = rid; v.rmask = rmask; v.st = st; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] wid, input logic [1:0] id,
                       input logic [1:0] sz, input logic noop, input logic rr);
    bar_valid = v; bar_wid = wid; bar_id = id; bar_size_m1 = sz;
    bar_is_noop = noop; release_ready = rr;
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset = v.rst_n;
    drive(v.valid, v.wid, v.id, v.sz, v.noop, v.rr);
    #1;
    chk($sformatf("row%0d bar_ready", idx), bar_ready, v.br);
    @(posedge clk); #1;
    chk($sformatf("row%0d release_valid", idx), release_valid, v.rv);
    chk($sformatf("row%0d release_id", idx), release_id, v.rid);
    chk($sformatf("row%0d release_wmask", idx), release_wmask, v.rmask);
    chk($sformatf("row%0d stalled_wmask", idx), stalled_wmask, v.st);
    chk($sformatf("row%0d busy", idx), busy, v.bsy);
    if (!PERF_ON) chk($sformatf("row%0d perf", idx), perf_stall_cycles, 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset release_valid", release_valid, 64'd0);
    chk("reset release_wmask", release_wmask, 64'd0);
    chk("reset stalled_wmask", stalled_wmask, 64'd0);
    chk("reset busy", busy, 64'd0);
    chk("reset perf", perf_stall_cycles, 64'd0);
    chk("reset bar_ready", bar_ready, 64'd1);

    // rst valid wid id sz noop rr | br rv rid rmask st busy
    // 4-warp barrier on slot 1
    vecs.push_back(mk(1, 1, 0, 1, 3, 0, 1,  1, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(1, 1, 1, 1, 3, 0, 1,  1, 0, 0, 4'b0000, 4'b0011, 1));
    vecs.push_back(mk(1, 1, 2, 1, 3, 0, 1,  1, 0, 0, 4'b0000, 4'b0111, 1));
    vecs.push_back(mk(1, 1, 3, 1, 3, 0, 1,  1, 1, 1, 4'b1111, 4'b0000, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 4'b0000, 4'b0000, 0));
    // interleaved barriers and noop
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1,  1, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(1, 1, 2, 3, 1, 0, 1,  1, 0, 0, 4'b0000, 4'b0101, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1,  1, 0, 0, 4'b0000, 4'b0101, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 1,  1, 1, 0, 4'b0011, 4'b0100, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 4'b0000, 4'b0100, 1));
    vecs.push_back(mk(1, 1, 3, 3, 1, 0, 1,  1, 1, 3, 4'b1100, 4'b0000, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 4'b0000, 4'b0000, 0));
    // size_m1 = 0 releases at once
    vecs.push_back(mk(1, 1, 2, 2, 0, 0, 1,  1, 1, 2, 4'b0100, 4'b0000, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 4'b0000, 4'b0000, 0));
    // duplicate arrival of warp 0 must not advance the count
    vecs.push_back(mk(1, 1, 0, 0, 2, 0, 1,  1, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(1, 1, 0, 0, 2, 0, 1,  1, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(1, 1, 1, 0, 2, 0, 1,  1, 0, 0, 4'b0000, 4'b0011, 1));
    vecs.push_back(mk(1, 1, 2, 0, 2, 0, 1,  1, 1, 0, 4'b0111, 4'b0000, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 4'b0000, 4'b0000, 0));
    // reset mid-operation: 3 stalled plus a pending release
    vecs.push_back(mk(1, 1, 0, 1, 3, 0, 1,  1, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(1, 1, 1, 1, 3, 0, 1,  1, 0, 0, 4'b0000, 4'b0011, 1));
    vecs.push_back(mk(1, 1, 2, 1, 3, 0, 1,  1, 0, 0, 4'b0000, 4'b0111, 1));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0,  1, 1, 0, 4'b1000, 4'b0111, 1));
    vecs.push_back(mk(0, 1, 3, 1, 3, 0, 0,  0, 0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1,  1, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1,  1, 1, 1, 4'b0011, 4'b0000, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 4'b0000, 4'b0000, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Back-pressure: pending release blocks a second completion until drained.
    reset = 1'b1;
    drive(1'b1, 2'd3, 2'd2, 2'd0, 1'b0, 1'b0);
    #1; chk("bp first bar_ready", bar_ready, 64'd1);
    @(posedge clk); #1;
    chk("bp first release_valid", release_valid, 64'd1);
    chk("bp first release_wmask", release_wmask, 64'h8);
    drive(1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1; chk($sformatf("bp hold%0d bar_ready", k), bar_ready, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d release_valid", k), release_valid, 64'd1);
      chk($sformatf("bp hold%0d release_id", k), release_id, 64'd2);
      chk($sformatf("bp hold%0d release_wmask", k), release_wmask, 64'h8);
    end
    release_ready = 1'b1;
    #1; chk("bp drain bar_ready", bar_ready, 64'd1);
    @(posedge clk); #1;
    chk("bp new release_valid", release_valid, 64'd1);
    chk("bp new release_wmask", release_wmask, 64'h1);
    chk("bp new stalled_wmask", stalled_wmask, 64'd0);
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("bp idle release_valid", release_valid, 64'd0);
    chk("bp idle busy", busy, 64'd0);

    // Stall counter: two warps stalled for five cycles.
    reset = 1'b0;
    @(posedge clk); #1;
    chk("perf after reset", perf_stall_cycles, 64'd0);
    reset = 1'b1;
    drive(1'b1, 2'd0, 2'd0, 2'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 2'd1, 2'd0, 2'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("perf stalled_wmask", stalled_wmask, 64'h3);
    chk("perf start", perf_stall_cycles, PERF_ON ? 64'd1 : 64'd0);
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("perf after 5 cycles", perf_stall_cycles, PERF_ON ? 64'd11 : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_barrier_table.md
# vx_barrier_table

Parametrised warp barrier table for the core's warp-control path. It generalises the single `barrier_t` request (`id`, `size_m1`, `is_noop`) into `NUM_BARRIERS` concurrent local barriers. Each barrier tracks arrivals per warp, holds arriving warps stalled, and emits a registered release mask with a valid/ready handshake to the warp scheduler. It sits between the SFU warp-control unit and the scheduler's stall logic.

## Interface
- `NUM_WARPS`, 4: warps per core; `NW_W = CLOG2(NUM_WARPS)`, minimum 1.
- `NUM_BARRIERS`, 4: barrier slots; `NB_W = CLOG2(NUM_BARRIERS)`, minimum 1.
- `PERF_CTR_BITS`, 44: width of the stall counter.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low (asserted when 0). Sampled only at `posedge clk`.
- `bar_valid` in 1: barrier arrival request.
- `bar_ready` out 1: arrival accepted when `bar_valid && bar_ready`.
- `bar_wid` in NW_W: arriving warp id.
- `bar_id` in NB_W: barrier slot.
- `bar_size_m1` in NW_W: participating warps minus one.
- `bar_is_noop` in 1: accept and discard.
- `release_valid` out 1: a barrier completed.
- `release_ready` in 1: scheduler consumes the release.
- `release_id` out NB_W: the completed barrier.
- `release_wmask` out NUM_WARPS: warps to resume.
- `stalled_wmask` out NUM_WARPS: OR of all barrier arrival masks, registered.
- `busy` out 1: any barrier has a nonzero count, or `release_valid` is high.
- `perf_stall_cycles` out PERF_CTR_BITS: warp-cycles spent stalled.

## Operation
- Each slot b holds `count[b]` (NW_W bits) and `wmask[b]` (NUM_WARPS bits). Both are 0 at reset.
- `bar_ready = !release_valid || release_ready`.
- **Accepted noop:** no state change and no release.
- **Accepted arrival, `count[b] == bar_size_m1`:** completes the barrier.
  - Release register loads `release_id = b` and `release_wmask = wmask[b] | onehot(bar_wid)`.
  - `release_valid` is set.
  - `count[b]` and `wmask[b]` clear.
- **Accepted arrival, otherwise:** `wmask[b] |= onehot(bar_wid)` and `count[b]++`.
- **Duplicate arrival** (warp already set in `wmask[b]`): state unchanged and no release. A simulation assertion flags it.
- **`bar_size_m1 = 0`:** releases immediately with a one-hot mask. The warp never appears in `stalled_wmask`.
- The `size_m1` of the completing arrival is authoritative. No consistency check is made across arrivals.
- **Release handshake:** `release_valid` holds, with `release_id` and `release_wmask` stable, until `release_valid && release_ready`.
  - At most one release is outstanding; a full release register back-pressures arrivals.
  - A release consumed in cycle t and a completing arrival in cycle t are both accepted; the new release is valid at t+1.
- `stalled_wmask` is the registered OR of all `wmask[b]` after the update. Warps in a pending release are not included.
- **Reset:** mid-operation, reset clears all slots, the release register and the counter. All outputs are 0 in the cycle after reset is sampled low, except `bar_ready`, which is 1.

## Timing
- Arrival accepted at edge t: `stalled_wmask` and `busy` reflect it from t+1.
- Completing arrival at edge t: `release_valid` is 1 from t+1, and the released bits drop from `stalled_wmask` at t+1.
- No combinational path from `bar_*` to `release_*` or `stalled_wmask`.
- The only combinational path is `release_ready -> bar_ready`.

## Configuration
- **`BAR_PERF_EN` defined:**
  - `perf_stall_cycles` adds `popcount(stalled_wmask)` every cycle reset is deasserted.
  - It wraps modulo 2^PERF_CTR_BITS and resets to 0.
- **`BAR_PERF_EN` undefined:** `perf_stall_cycles` is tied to 0 and the counter logic is absent. All other behaviour is identical.

## Test plan
- **4-warp barrier:** NUM_WARPS=4; arrivals on barrier 1 with size_m1=3 from warps 0,1,2 on consecutive cycles.
  - `stalled_wmask` goes 0001, 0011, 0111.
  - Warp 3 arrives -> next cycle `release_valid=1`, `release_id=1`, `release_wmask=1111`, `stalled_wmask=0000`.
- **Back-pressure:** `release_ready=0` with a pending release; offer an arrival.
  - `bar_ready=0` and the arrival is held.
  - Raise `release_ready` -> the arrival is accepted in the same cycle.
- **Interleaved barriers and noop:**
  - Warp 0 -> barrier 0 (size_m1=1), warp 2 -> barrier 3 (size_m1=1), noop from warp 1 -> `stalled_wmask=0101`, no release.
  - Warp 1 -> barrier 0 -> release mask 0011.
- **Edge cases:**
  - size_m1=0 from warp 2 -> release mask 0100 next cycle; `stalled_wmask` stays 0.
  - Duplicate arrival of warp 0 -> count unchanged and the assertion fires.
- **Reset mid-operation:** drive reset low with 3 warps stalled and a release pending.
  - Next cycle all outputs are 0 and `bar_ready=1`.
  - A subsequent size_m1=1 barrier needs 2 fresh arrivals.
- **`BAR_PERF_EN`:**
  - 2 warps stalled for 5 cycles -> `perf_stall_cycles=10`.
  - Without the macro -> it stays 0.
